// File: rtl/bcd_scan_counter.sv
// Four-digit packed-BCD up-counter with a time-multiplexed digit scanner.
// Each scan slot presents one BCD digit and its active-low anode select.
module bcd_scan_counter #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] value,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        carry
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [15:0]   r_value;
  logic          r_carry;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_idx;

  logic [15:0]   w_value_inc;
  logic          w_wrap;

  // Ripple the decimal carry from units upward; a 9 rolls to 0 and passes carry on.
  always_comb begin : bcd_inc
    logic v_c;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_value_inc = r_value;
    v_c         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_c) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_value_inc[4*i +: 4] = 4'd0;
        end else begin
          w_value_inc[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          v_c = 1'b0;
        end
      end
    end
    w_wrap = v_c;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= 16'h0000;
      r_carry <= 1'b0;
    end else if (clr) begin
      r_value <= 16'h0000;
      r_carry <= 1'b0;
    end else if (inc) begin
      r_value <= w_value_inc;
      r_carry <= w_wrap;
    end else begin
      r_carry <= 1'b0;
    end
  end

  // The scanner free-runs; clr and inc never touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  always_comb begin
    digit = r_value[3:0];
    an    = 4'b1110;
    case (r_idx)
      2'd0: begin digit = r_value[3:0];   an = 4'b1110; end
      2'd1: begin digit = r_value[7:4];   an = 4'b1101; end
      2'd2: begin digit = r_value[11:8];  an = 4'b1011; end
      2'd3: begin digit = r_value[15:12]; an = 4'b0111; end
      default: begin digit = r_value[3:0]; an = 4'b1110; end
    endcase
  end

  assign value = r_value;
  assign carry = r_carry;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter: two instances (SCAN_DIV=4 and 1) share stimulus.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst_n, inc, clr;
  logic [15:0] value4, value1;
  logic [3:0]  digit4, digit1, an4, an1;
  logic        carry4, carry1;

  int n_checks = 0;
  int n_errors = 0;
  int t_slot   = 0;  // edges since last reset edge

  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] dig_tab [4] = '{4'd4, 4'd3, 4'd2, 4'd1};

  always #5 clk = ~clk;

  bcd_scan_counter #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .value(value4), .digit(digit4), .an(an4), .carry(carry4)
  );

  bcd_scan_counter #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr),
    .value(value1), .digit(digit1), .an(an1), .carry(carry1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) t_slot = 0;
    else        t_slot++;
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  initial begin
    logic [15:0] exp_v;
    int          sidx;
    rst_n = 1'b0; inc = 1'b1; clr = 1'b0;

    // Reset held for 3 edges with inc high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_value", value4, 16'h0000);
      check("rst_an",    an4,    4'b1110);
      check("rst_digit", digit4, 4'd0);
      check("rst_carry", carry4, 1'b0);
    end

    // 1200 continuous incs, every nibble, digit and anode checked.
    rst_n = 1'b1;
    for (int k = 1; k <= 1200; k++) begin
      tick();
      exp_v = to_bcd(k);
      sidx  = (t_slot / 4) % 4;
      check("count_value", value4, exp_v);
      check("count_carry", carry4, 1'b0);
      check("count_an",    an4,    an_tab[sidx]);
      check("count_digit", digit4, exp_v[4*sidx +: 4]);
      check("count_an1",   an1,    an_tab[t_slot % 4]);
      if (k == 10)   check("carry_9_to_10",    value4, 16'h0010);
      if (k == 1000) check("carry_999_to_1000", value4, 16'h1000);
    end

    // Run up to 9999, then wrap.
    for (int k = 1201; k <= 9999; k++) tick();
    check("at_9999", value4, 16'h9999);
    check("at_9999_div1", value1, 16'h9999);
    check("pre_wrap_carry", carry4, 1'b0);
    tick();
    check("wrap_value", value4, 16'h0000);
    check("wrap_carry", carry4, 1'b1);
    check("wrap_carry_div1", carry1, 1'b1);
    inc = 1'b0;
    tick();
    check("post_wrap_value", value4, 16'h0000);
    check("post_wrap_carry", carry4, 1'b0);

    // Clear has priority over inc and leaves the scanner alone.
    inc = 1'b1;
    for (int k = 0; k < 42; k++) tick();
    check("at_0042", value4, 16'h0042);
    clr = 1'b1;
    tick();
    check("clr_value", value4, 16'h0000);
    check("clr_carry", carry4, 1'b0);
    check("clr_an",    an4,    an_tab[(t_slot / 4) % 4]);
    check("clr_an1",   an1,    an_tab[t_slot % 4]);
    clr = 1'b0;
    tick();
    check("after_clr_value", value4, 16'h0001);
    check("after_clr_an",    an4,    an_tab[(t_slot / 4) % 4]);

    // Scan sequence with value 0x1234, aligned to a refresh boundary (1248 = 78*16).
    rst_n = 1'b0; inc = 1'b0;
    tick();
    rst_n = 1'b1; inc = 1'b1;
    for (int k = 0; k < 1234; k++) tick();
    inc = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    check("scan_value", value4, 16'h1234);
    for (int t = 0; t < 32; t++) begin
      check("scan4_an",    an4,    an_tab[(t / 4) % 4]);
      check("scan4_digit", digit4, dig_tab[(t / 4) % 4]);
      check("scan1_an",    an1,    an_tab[t % 4]);
      check("scan1_digit", digit1, dig_tab[t % 4]);
      tick();
    end

    // Mid-slot reset at idx2, scan_cnt 2, value 0x0500 (500 incs + 6 idle = 506 = 16*31 + 10).
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; inc = 1'b1;
    for (int k = 0; k < 500; k++) tick();
    inc = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_value", value4, 16'h0500);
    check("mid_an",    an4,    4'b1011);
    rst_n = 1'b0; inc = 1'b1;
    tick();
    check("mid_rst_value", value4, 16'h0000);
    check("mid_rst_an",    an4,    4'b1110);
    check("mid_rst_digit", digit4, 4'd0);
    rst_n = 1'b1; inc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idx0_held", an4, 4'b1110);
    end
    tick();
    check("idx1_after_slot", an4, 4'b1101);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
# bcd_scan_counter

Four-digit packed-BCD up-counter with a time-multiplexed digit scanner. It sits directly upstream of the `bcd7seg` decoder. Each scan slot presents one 4-bit BCD digit on `digit`, which drives the decoder's `cin`, together with an active-low one-hot anode select. The block turns a count strobe into a stable, scanned 4-digit display stream.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays selected. Legal range is ≥1.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `rst_n` input 1: reset; synchronous and active-low.
- `inc` input 1: count strobe; +1 per cycle sampled high.
- `clr` input 1: synchronous clear of the count; does not affect the scanner.
- `value` output 16: packed BCD count. [15:12] = thousands, [3:0] = units.
- `digit` output 4: BCD nibble of the currently selected digit; connects to `bcd7seg.cin`.
- `an` output 4: anode select, active-low one-hot. Bit i low means digit i is shown.
- `carry` output 1: one-cycle pulse on wrap 9999→0000.

## Operation
- Count register: four BCD nibbles d3..d0, each always in 0..9.
- Increment rule on a cycle with `inc`=1 and `clr`=0:
  - d0+1; a nibble equal to 9 becomes 0 and propagates carry to the next nibble.
  - Non-9 nibbles above the carry chain are unchanged.
  - Binary values 10–15 never appear in any nibble.
- Wrap: 9999 + `inc` gives 0000, and `carry`=1 on the same edge for exactly one cycle. Otherwise `carry`=0.
- Priority is `rst_n` low, then `clr`, then `inc`. `clr`=1 with `inc`=1 gives 0000 and `carry`=0.
- Scanner:
  - Prescaler `scan_cnt` counts 0..SCAN_DIV-1.
  - On the edge where `scan_cnt`=SCAN_DIV-1, it wraps to 0 and the digit index `idx` advances 0→1→2→3→0.
  - SCAN_DIV=1 advances `idx` every cycle.
- `an` is a combinational decode of `idx`: idx0=1110, idx1=1101, idx2=1011, idx3=0111. Exactly one bit is low at all times.
- `digit` is the combinational nibble of `value` selected by `idx`: idx0→[3:0], idx1→[7:4], idx2→[11:8], idx3→[15:12].
- Scanning runs continuously and is independent of `inc` and `clr`.
- Reset values (`rst_n` low at a rising edge): `value`=0x0000, `idx`=0, `scan_cnt`=0, `carry`=0, which gives `an`=1110 and `digit`=0.
- Reset asserted mid-count or mid-scan slot takes effect on the next edge, discarding the partial slot and any pending `inc`.

## Timing
- Count latency: `inc` high at edge N gives the new `value` (and `carry` if applicable) visible after edge N.
- Back-to-back `inc` for K cycles adds exactly K, modulo 10000.
- `digit` and `an` change only after an edge that changes `idx` or `value`. Within a slot, a count change updates `digit` immediately; `an` is unchanged.
- Slot length is exactly SCAN_DIV cycles. A full refresh of all 4 digits takes 4·SCAN_DIV cycles.
- After reset release, idx0 is held for SCAN_DIV cycles, then idx1.
- No handshake. `inc` and `clr` are level-sampled every edge and must be synchronous to `clk`.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 edges with `inc`=1 → `value`=0x0000, `an`=1110, `digit`=0, `carry`=0 throughout.
- **Decimal carry:** from 0x0009, one `inc` → 0x0010. From 0x0999, one `inc` → 0x1000, `carry`=0. No nibble ever exceeds 9 over 1200 continuous `inc` cycles.
- **Wrap:** preload to 9999 via 9999 `inc` pulses, then one `inc` → `value`=0x0000 and `carry`=1 for exactly one cycle, then 0.
- **Clear priority:** at `value`=0x0042, drive `clr`=1 and `inc`=1 together → 0x0000 next cycle. Then `clr`=0, `inc`=1 → 0x0001. Scanner slot/idx is unaffected by the `clr`.
- **Scan sequence:** SCAN_DIV=4, `value`=0x1234.
  - `an`/`digit` cycle 1110/4, 1101/3, 1011/2, 0111/1, each held exactly 4 cycles, then repeat.
  - Repeat with SCAN_DIV=1: the idx changes every cycle.
- **Mid-operation reset:** SCAN_DIV=4, assert `rst_n`=0 one cycle at idx2 with `scan_cnt`=2 and `value`=0x0500 → next cycle `value`=0x0000, `an`=1110. Then idx0 is held a full 4 cycles.
